mult_wide_seq: RTL and testbench

- Parametrised, limb-serial wide multiplier: A_W x B_W, selectable unsigned or two's-complement operands.
- Successor to the fixed-width split multipliers in the mm datapath. B is cut into LIMB_W limbs, and the limbs are issued one per cycle into a single pipelined A_W x LIMB_W sub-multiplier.
- Partial products are shift-accumulated into a full-width result.
- valid/ready on input and output. Sits between the modular-reduction front end and the accumulation stage.

---
 rtl/mm_pkg.sv | 30 +++
 rtl/mult_wide_seq_if.sv | 28 ++
 rtl/mult_wide_seq_limb_pipe.sv | 61 ++++++
 rtl/mult_wide_seq.sv | 163 ++++++++++++++++
 tb/tb_mult_wide_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the mm datapath multipliers.
//   clog2      - ceiling log2 for sizing counters (clog2(1) = 0).
//   num_limbs  - number of LIMB_W-wide limbs needed to cover a B_W-wide operand.
//   mult_seq_state_t - control states of the limb-serial wide multiplier.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIX,
        DONE
    } mult_seq_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(value)) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned num_limbs(input int unsigned b_w, input int unsigned limb_w);
        return (b_w + limb_w - 1) / limb_w;
    endfunction

endpackage

// File: rtl/mult_wide_seq_if.sv
// mult_wide_seq_if: operand/result handshake bundle of the wide multiplier.
//   in_valid/in_ready : operand handshake (a, b, signed_i travel with it)
//   out_valid/out_ready : result handshake (p travels with it)
//   slave  modport : multiplier side
//   master modport : producer/consumer side
interface mult_wide_seq_if #(
    parameter int unsigned A_W = 149,
    parameter int unsigned B_W = 80
);
    logic                 in_valid;
    logic                 in_ready;
    logic [A_W-1:0]       a;
    logic [B_W-1:0]       b;
    logic                 signed_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [A_W+B_W-1:0]   p;

    modport slave (
        input  in_valid, a, b, signed_i, out_ready,
        output in_ready, out_valid, p
    );

    modport master (
        output in_valid, a, b, signed_i, out_ready,
        input  in_ready, out_valid, p
    );
endinterface

// File: rtl/mult_wide_seq_limb_pipe.sv
// mult_limb_pipe: unsigned A_W x LIMB_W multiplier with MUL_LAT register
// stages; a valid bit and the limb index ride alongside the product.
//   clk, rst_n          : clock, synchronous active-low reset (clears valids)
//   in_valid/in_a/in_limb/in_idx : issue side
//   out_valid/out_prod/out_idx   : product MUL_LAT cycles later
module mult_limb_pipe #(
    parameter int unsigned A_W     = 149,
    parameter int unsigned LIMB_W  = 16,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [A_W-1:0]         in_a,
    input  logic [LIMB_W-1:0]      in_limb,
    input  logic [IDX_W-1:0]       in_idx,
    output logic                   out_valid,
    output logic [A_W+LIMB_W-1:0]  out_prod,
    output logic [IDX_W-1:0]       out_idx
);
    localparam int unsigned PW = A_W + LIMB_W;

    logic [MUL_LAT-1:0] vld_d, vld_q;
    logic [PW-1:0]      prod_d [MUL_LAT];
    logic [PW-1:0]      prod_q [MUL_LAT];
    logic [IDX_W-1:0]   idx_d  [MUL_LAT];
    logic [IDX_W-1:0]   idx_q  [MUL_LAT];

    // The product is formed ahead of the first register; later stages only
    // delay it, leaving synthesis free to retime the multiplier across them.
    always_comb begin
        vld_d[0]  = in_valid;
        prod_d[0] = PW'(in_a) * PW'(in_limb);
        idx_d[0]  = in_idx;
        for (int unsigned k = 1; k < MUL_LAT; k++) begin
            vld_d[k]  = vld_q[k-1];
            prod_d[k] = prod_q[k-1];
            idx_d[k]  = idx_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < MUL_LAT; k++) begin
            prod_q[k] <= prod_d[k];
            idx_q[k]  <= idx_d[k];
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_prod  = prod_q[MUL_LAT-1];
    assign out_idx   = idx_q[MUL_LAT-1];
endmodule

// File: rtl/mult_wide_seq.sv
// mult_wide_seq: limb-serial A_W x B_W multiplier, unsigned or two's complement.
// b is cut into LIMB_W limbs issued one per cycle into mult_limb_pipe; the
// partial products are shift-accumulated on magnitudes and the sign applied
// at the end.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, aborts any job in flight
//   bus   : slave side of mult_wide_seq_if (in_valid/in_ready/a/b/signed_i,
//           out_valid/out_ready/p)
module mult_wide_seq
    import mm_pkg::*;
#(
    parameter int unsigned A_W     = 149,
    parameter int unsigned B_W     = 80,
    parameter int unsigned LIMB_W  = 16,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_wide_seq_if.slave bus
);
    localparam int unsigned NUM_LIMBS = num_limbs(B_W, LIMB_W);
    localparam int unsigned IDX_W     = (clog2(NUM_LIMBS) > 0) ? clog2(NUM_LIMBS) : 1;
    localparam int unsigned B_PAD     = NUM_LIMBS * LIMB_W;
    localparam int unsigned P_W       = A_W + B_W;
    localparam int unsigned PP_W      = A_W + LIMB_W;
    localparam int unsigned WIDE_W    = A_W + B_PAD;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

    mult_seq_state_t  state_q, state_d;
    logic [A_W-1:0]   a_cap_q, a_cap_d;
    logic [B_PAD-1:0] b_cap_q, b_cap_d;
    logic             neg_q, neg_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [P_W-1:0]   p_q, p_d;

    logic [A_W-1:0]    a_mag;
    logic [B_W-1:0]    b_mag;
    logic              in_neg;

    logic              iss_valid;
    logic [A_W-1:0]    iss_a;
    logic [LIMB_W-1:0] iss_limb;
    logic [IDX_W-1:0]  iss_idx;

    logic              pp_valid;
    logic [PP_W-1:0]   pp_prod;
    logic [IDX_W-1:0]  pp_idx;
    logic [WIDE_W-1:0] pp_shifted;

    // Magnitudes of the incoming operands; -2^(W-1) maps onto 2^(W-1).
    always_comb begin
        a_mag  = (bus.signed_i && bus.a[A_W-1]) ? -bus.a : bus.a;
        b_mag  = (bus.signed_i && bus.b[B_W-1]) ? -bus.b : bus.b;
        in_neg = bus.signed_i && (bus.a[A_W-1] ^ bus.b[B_W-1]);
    end

    mult_limb_pipe #(
        .A_W     (A_W),
        .LIMB_W  (LIMB_W),
        .MUL_LAT (MUL_LAT),
        .IDX_W   (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iss_valid),
        .in_a      (iss_a),
        .in_limb   (iss_limb),
        .in_idx    (iss_idx),
        .out_valid (pp_valid),
        .out_prod  (pp_prod),
        .out_idx   (pp_idx)
    );

    always_comb begin
        pp_shifted = WIDE_W'(pp_prod) << (32'(pp_idx) * LIMB_W);
    end

    // Limb 0 is issued straight from the accepted operands on the accept
    // edge, so ISSUE only walks limbs 1..NUM_LIMBS-1. This keeps the accept
    // to out_valid latency at NUM_LIMBS+MUL_LAT+1 with a registered FIX step.
    always_comb begin
        state_d  = state_q;
        a_cap_d  = a_cap_q;
        b_cap_d  = b_cap_q;
        neg_d    = neg_q;
        i_d      = i_q;
        acc_d    = acc_q;
        p_d      = p_q;

        iss_valid = 1'b0;
        iss_a     = a_cap_q;
        iss_limb  = LIMB_W'(b_cap_q >> (32'(i_q) * LIMB_W));
        iss_idx   = i_q;

        if (pp_valid) begin
            acc_d = acc_q + P_W'(pp_shifted);
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_cap_d   = a_mag;
                    b_cap_d   = B_PAD'(b_mag);
                    neg_d     = in_neg;
                    acc_d     = '0;
                    iss_valid = 1'b1;
                    iss_a     = a_mag;
                    iss_limb  = b_mag[LIMB_W-1:0];
                    iss_idx   = '0;
                    i_d       = IDX_W'(1);
                    state_d   = (NUM_LIMBS > 1) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                iss_valid = 1'b1;
                i_d       = i_q + 1'b1;
                if (i_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pp_valid && (pp_idx == LAST_IDX)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                p_d     = neg_q ? -acc_q : acc_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_cap_q <= '0;
            b_cap_q <= '0;
            neg_q   <= 1'b0;
            i_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_cap_q <= a_cap_d;
            b_cap_q <= b_cap_d;
            neg_q   <= neg_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE) && rst_n;
    assign bus.p         = p_q;
endmodule

// File: tb/tb_mult_wide_seq.sv
// Self-checking bench for mult_wide_seq: a 149x80 instance (16-bit limbs,
// MUL_LAT=2) and a 20x20 instance (16-bit limbs, MUL_LAT=1, 4-bit top limb).
// Latency is counted as clock edges from the accept edge to the edge at
// which out_valid is first sampled high.
module tb_mult_wide_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_wide_seq_if #(.A_W(149), .B_W(80)) big_if ();
    mult_wide_seq_if #(.A_W(20),  .B_W(20)) sm_if ();

    mult_wide_seq #(.A_W(149), .B_W(80), .LIMB_W(16), .MUL_LAT(2)) dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (big_if)
    );

    mult_wide_seq #(.A_W(20), .B_W(20), .LIMB_W(16), .MUL_LAT(1)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sm_if)
    );

    typedef struct {
        logic [148:0] a;
        logic [79:0]  b;
        logic         s;
        logic [228:0] exp_p;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [228:0] ref_big(input logic [148:0] a, input logic [79:0] b, input logic s);
        logic [228:0] ea, eb;
        ea = s ? {{80{a[148]}}, a} : {80'b0, a};
        eb = s ? {{149{b[79]}}, b} : {149'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [39:0] ref_small(input logic [19:0] a, input logic [19:0] b, input logic s);
        logic [39:0] ea, eb;
        ea = s ? {{20{a[19]}}, a} : {20'b0, a};
        eb = s ? {{20{b[19]}}, b} : {20'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [148:0] rand_a();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[148:0];
    endfunction

    function automatic logic [79:0] rand_b();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[79:0];
    endfunction

    // Drives one job into the big instance and returns at the negedge where
    // out_valid is first seen high (no handshake is done here).
    task automatic job_big(input logic [148:0] a, input logic [79:0] b, input logic s,
                           output logic [228:0] p, output int lat);
        int n;
        @(negedge clk);
        big_if.a = a; big_if.b = b; big_if.signed_i = s; big_if.in_valid = 1'b1;
        n = 0;
        while (!big_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("big accept");
        @(posedge clk);
        @(negedge clk);
        big_if.in_valid = 1'b0;
        big_if.a = ~a; big_if.b = ~b; big_if.signed_i = ~s;
        lat = 1;
        while (!big_if.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) timeout("big out_valid");
        p = big_if.p;
    endtask

    task automatic job_small(input logic [19:0] a, input logic [19:0] b, input logic s,
                             output logic [39:0] p, output int lat);
        int n;
        @(negedge clk);
        sm_if.a = a; sm_if.b = b; sm_if.signed_i = s; sm_if.in_valid = 1'b1;
        n = 0;
        while (!sm_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("small accept");
        @(posedge clk);
        @(negedge clk);
        sm_if.in_valid = 1'b0;
        sm_if.a = ~a; sm_if.b = ~b; sm_if.signed_i = ~s;
        lat = 1;
        while (!sm_if.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) timeout("small out_valid");
        p = sm_if.p;
    endtask

    vec_t vecs[10];

    initial begin
        logic [229:0] t;
        logic [228:0] pg, held;
        logic [39:0]  ps;
        int lat;
        bit seen;

        // ---------------- vector table (hand-derived products) ----------------
        t = (230'd1 << 229) - (230'd1 << 149) - (230'd1 << 80) + 230'd1;
        vecs[0] = '{a: {149{1'b1}}, b: {80{1'b1}}, s: 1'b0, exp_p: t[228:0]};
        vecs[1] = '{a: {149{1'b1}}, b: {80{1'b1}}, s: 1'b1, exp_p: 229'd1};
        vecs[2] = '{a: 149'd1 << 148, b: (80'd1 << 79) - 80'd1, s: 1'b1,
                    exp_p: 229'd0 - ((229'd1 << 227) - (229'd1 << 148))};
        vecs[3] = '{a: 149'd3, b: 80'd5, s: 1'b0, exp_p: 229'd15};
        vecs[4] = '{a: 149'd0 - 149'd3, b: 80'd5, s: 1'b1, exp_p: 229'd0 - 229'd15};
        vecs[5] = '{a: 149'd1 << 148, b: 80'd2, s: 1'b0, exp_p: 229'd1 << 149};
        vecs[6] = '{a: 149'd7, b: 80'd1 << 79, s: 1'b1, exp_p: 229'd0 - (229'd7 << 79)};
        vecs[7] = '{a: 149'd0, b: 80'hdead_beef_0123_4567_89ab, s: 1'b1, exp_p: 229'd0};
        vecs[8] = '{a: 149'h1234_5678_9abc, b: (80'd1 << 64) + 80'd1, s: 1'b0,
                    exp_p: (229'h1234_5678_9abc << 64) + 229'h1234_5678_9abc};
        vecs[9] = '{a: {149{1'b1}}, b: 80'd5, s: 1'b1, exp_p: 229'd0 - 229'd5};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        big_if.in_valid = 1'b0; big_if.out_ready = 1'b1;
        big_if.a = '0; big_if.b = '0; big_if.signed_i = 1'b0;
        sm_if.in_valid = 1'b0; sm_if.out_ready = 1'b1;
        sm_if.a = '0; sm_if.b = '0; sm_if.signed_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 256'(big_if.in_ready), 256'd0);
        check("reset out_valid", 256'(big_if.out_valid), 256'd0);
        check("reset p", 256'(big_if.p), 256'd0);
        check("reset small in_ready", 256'(sm_if.in_ready), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after release", 256'(big_if.in_ready), 256'd1);

        // ---------------- table-driven directed vectors ----------------
        for (int k = 0; k < 10; k++) begin
            job_big(vecs[k].a, vecs[k].b, vecs[k].s, pg, lat);
            check($sformatf("vec%0d p", k), 256'(pg), 256'(vecs[k].exp_p));
            check($sformatf("vec%0d latency", k), 256'(lat), 256'd8);
        end

        // ---------------- backpressure ----------------
        @(negedge clk);
        big_if.out_ready = 1'b0;
        job_big(vecs[0].a, vecs[0].b, 1'b0, pg, lat);
        check("bp p", 256'(pg), 256'(vecs[0].exp_p));
        held = pg;
        big_if.a = 149'd9; big_if.b = 80'd9; big_if.signed_i = 1'b0; big_if.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp out_valid c%0d", c), 256'(big_if.out_valid), 256'd1);
            check($sformatf("bp p held c%0d", c), 256'(big_if.p), 256'(held));
            check($sformatf("bp in_ready c%0d", c), 256'(big_if.in_ready), 256'd0);
        end
        big_if.out_ready = 1'b1;
        big_if.in_valid = 1'b0;
        @(negedge clk);
        check("bp release in_ready", 256'(big_if.in_ready), 256'd1);
        check("bp release out_valid", 256'(big_if.out_valid), 256'd0);
        repeat (12) @(negedge clk);
        check("bp ignored job: no out_valid", 256'(big_if.out_valid), 256'd0);

        // ---------------- reset during ISSUE (limb 2) ----------------
        big_if.a = {149{1'b1}}; big_if.b = {80{1'b1}}; big_if.signed_i = 1'b0;
        big_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        big_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort in_ready in reset", 256'(big_if.in_ready), 256'd0);
        check("abort p cleared", 256'(big_if.p), 256'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (big_if.out_valid) seen = 1'b1;
        end
        check("abort no output", 256'(seen), 256'd0);
        job_big(149'd3, 80'd5, 1'b0, pg, lat);
        check("post-abort p", 256'(pg), 256'd15);
        check("post-abort latency", 256'(lat), 256'd8);

        // ---------------- back-to-back random jobs ----------------
        begin
            logic [228:0] expq[$];
            logic [228:0] e;
            int jobs_in, jobs_out, cyc, last_acc;
            bit acc_now;
            jobs_in = 0; jobs_out = 0; cyc = 0; last_acc = -1;
            @(negedge clk);
            big_if.a = rand_a(); big_if.b = rand_b(); big_if.signed_i = 1'($urandom_range(0, 1));
            big_if.in_valid = 1'b1;
            while (jobs_out < 50 && cyc < 1000) begin
                if (big_if.out_valid) begin
                    if (expq.size() == 0) begin
                        timeout("b2b unexpected result");
                    end else begin
                        e = expq.pop_front();
                        check($sformatf("b2b p job%0d", jobs_out), 256'(big_if.p), 256'(e));
                    end
                    jobs_out++;
                end
                acc_now = big_if.in_valid && big_if.in_ready;
                if (acc_now) begin
                    expq.push_back(ref_big(big_if.a, big_if.b, big_if.signed_i));
                    if (last_acc >= 0) check($sformatf("b2b spacing job%0d", jobs_in), 256'(cyc - last_acc), 256'd9);
                    last_acc = cyc;
                    jobs_in++;
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (acc_now) begin
                    if (jobs_in < 50) begin
                        big_if.a = rand_a(); big_if.b = rand_b();
                        big_if.signed_i = 1'($urandom_range(0, 1));
                    end else begin
                        big_if.in_valid = 1'b0;
                    end
                end
            end
            if (cyc >= 1000) timeout("b2b completion");
        end

        // ---------------- small instance: 1000 random pairs ----------------
        for (int k = 0; k < 1000; k++) begin
            logic [19:0] ra, rb;
            logic rs;
            ra = 20'($urandom);
            rb = 20'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (k % 10 == 1) ra = 20'h80000;
            if (k % 10 == 2) rb = 20'h80000;
            if (k % 10 == 3) rb = 20'hfffff;
            job_small(ra, rb, rs, ps, lat);
            check($sformatf("small p #%0d", k), 256'(ps), 256'(ref_small(ra, rb, rs)));
            check($sformatf("small latency #%0d", k), 256'(lat), 256'd4);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
